// File: rtl/norm_seq.sv
// Sequential magnitude normaliser: buffers a vector, then emits |x|/sum(|x|) per element
// via a restoring divider. Define NORM_SIGNED_OUT_EN to carry the element sign onto out.
module norm_seq #(
  parameter  int bw    = 4,
  parameter  int depth = 16,
  parameter  int frac  = 8,
  localparam int sw    = bw + $clog2(depth),
  localparam int ow    = frac + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] in,
  input  logic          wr,
  input  logic          div,
  output logic [ow-1:0] out,
  output logic          o_valid,
  output logic          o_ready,
  output logic          o_full,
  output logic          o_empty
);
  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(frac + 2);
`ifdef NORM_SIGNED_OUT_EN
  localparam int ew = bw + 1;
`else
  localparam int ew = bw;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

  state_t        state_q, state_d;
  logic [ew-1:0] mem_q [depth];
  logic [aw-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [aw:0]   cnt_q, cnt_d;
  logic [sw-1:0] sum_q, sum_d;
  logic [sw:0]   rem_q, rem_d;
  logic [frac:0] quo_q, quo_d;
  logic [cw-1:0] it_q, it_d;
  logic [ow-1:0] out_q, out_d;
  logic          vld_q, vld_d;
`ifdef NORM_SIGNED_OUT_EN
  logic          sign_q, sign_d;
`endif

  logic [bw-1:0] mag;
  logic [ew-1:0] wr_data, rd_data;
  logic          push, ge;
  logic [sw-1:0] diff;
  logic [ow-1:0] res;

  always_comb begin
    mag     = in[bw-1] ? (~in + bw'(1)) : in;
`ifdef NORM_SIGNED_OUT_EN
    wr_data = {in[bw-1], mag};
`else
    wr_data = mag;
`endif
    rd_data = mem_q[rd_ptr_q];
    push    = (state_q == IDLE) && wr && !o_full;
    // remainder stays below 2*sum, so the low sw bits of the difference are exact
    ge      = rem_q >= {1'b0, sum_q};
    diff    = rem_q[sw-1:0] - sum_q;
    res     = {1'b0, quo_q};

    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    it_d     = it_q;
    out_d    = out_q;
    vld_d    = 1'b0;
`ifdef NORM_SIGNED_OUT_EN
    sign_d   = sign_q;
`endif

    case (state_q)
      IDLE: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + aw'(1);
          cnt_d    = cnt_q + (aw+1)'(1);
          sum_d    = sum_q + sw'(mag);
        end else if (div && !wr && !o_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        rd_ptr_d = rd_ptr_q + aw'(1);
        cnt_d    = cnt_q - (aw+1)'(1);
        // mag << frac is implicit: the divider shifts the remainder, not the numerator
        rem_d    = {1'b0, sw'(rd_data[bw-1:0])};
        quo_d    = '0;
        it_d     = cw'(frac + 1);
`ifdef NORM_SIGNED_OUT_EN
        sign_d   = rd_data[bw];
`endif
        state_d  = DIV;
      end
      DIV: begin
        if (sum_q != '0 && ge) begin
          quo_d = {quo_q[frac-1:0], 1'b1};
          rem_d = {diff, 1'b0};
        end else begin
          quo_d = {quo_q[frac-1:0], 1'b0};
          rem_d = {rem_q[sw-1:0], 1'b0};
        end
        it_d = it_q - cw'(1);
        if (it_q == cw'(1)) state_d = OUT;
      end
      OUT: begin
        vld_d = 1'b1;
`ifdef NORM_SIGNED_OUT_EN
        out_d = sign_q ? (~res + ow'(1)) : res;
`else
        out_d = res;
`endif
        if (cnt_q != '0) begin
          state_d = LOAD;
        end else begin
          sum_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      it_q     <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
`ifdef NORM_SIGNED_OUT_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      it_q     <= it_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
`ifdef NORM_SIGNED_OUT_EN
      sign_q   <= sign_d;
`endif
    end
  end

  // storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign out     = out_q;
  assign o_valid = vld_q;
  assign o_ready = (state_q == IDLE);
  assign o_full  = (cnt_q == (aw+1)'(depth));
  assign o_empty = (cnt_q == '0);

endmodule

// File: tb/tb_norm_seq.sv
// Scoreboard bench for norm_seq: stimulus pushes expected {value, cycle}; a negedge monitor pops on o_valid.
module tb_norm_seq;
  localparam int BW = 4, DEPTH = 8, FRAC = 8, OW = FRAC + 2, PER = FRAC + 3;
`ifdef NORM_SIGNED_OUT_EN
  localparam logic [OW-1:0] R_NEG2 = 10'h380;
  localparam logic [OW-1:0] R_NEG8 = 10'h300;
`else
  localparam logic [OW-1:0] R_NEG2 = 10'h080;
  localparam logic [OW-1:0] R_NEG8 = 10'h100;
`endif

  logic          clk = 1'b0, reset = 1'b1;
  logic [BW-1:0] in = '0;
  logic          wr = 1'b0, div = 1'b0;
  logic [OW-1:0] out;
  logic          o_valid, o_ready, o_full, o_empty;

  norm_seq #(.bw(BW), .depth(DEPTH), .frac(FRAC)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .div(div),
    .out(out), .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [OW-1:0] val; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got pulse out=%0h expected none (cycle %0d)", out, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("out", {22'd0, out}, {22'd0, mon_e.val});
        chk("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_elem(input logic [BW-1:0] v);
    in = v; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic start_div(output int t);
    div = 1'b1;
    t   = cyc + 1;
    tick();
    div = 1'b0;
  endtask

  task automatic push_exp(input logic [OW-1:0] v, input int c);
    exp_t e;
    e.val = v; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", o_ready, 1);
    chk("rst_empty", o_empty, 1);
    chk("rst_full",  o_full,  0);
    chk("rst_valid", o_valid, 0);
    chk("rst_out",   out,     0);

    // 1, -2, 1 -> 64, 128 (signed: -128), 64
    wr_elem(4'h1); wr_elem(4'hE); wr_elem(4'h1);
    chk("vecA_nonempty", o_empty, 0);
    start_div(t);
    push_exp(10'd64, t + PER); push_exp(R_NEG2, t + 2*PER); push_exp(10'd64, t + 3*PER);
    drain(60);
    chk("vecA_ready", o_ready, 1);
    chk("vecA_empty", o_empty, 1);

    // single -8: full-scale quotient; also shows sum was cleared
    wr_elem(4'h8);
    start_div(t);
    push_exp(R_NEG8, t + PER);
    drain(30);

    // all-zero vector takes the sum==0 path
    wr_elem(4'h0); wr_elem(4'h0); wr_elem(4'h0);
    start_div(t);
    for (int k = 1; k <= 3; k++) push_exp(10'd0, t + k*PER);
    drain(60);

    // fill, then a dropped write while full
    for (int k = 0; k < DEPTH; k++) wr_elem(4'h3);
    chk("full_after_8", o_full, 1);
    wr_elem(4'h7);
    chk("full_after_drop", o_full, 1);
    start_div(t);
    for (int k = 1; k <= DEPTH; k++) push_exp(10'd32, t + k*PER);
    drain(DEPTH*PER + 20);
    chk("full_cleared", o_full, 0);

    // wr and div together: store only
    in = 4'h5; wr = 1'b1; div = 1'b1;
    tick();
    wr = 1'b0; div = 1'b0;
    repeat (15) tick();
    chk("wrdiv_ready", o_ready, 1);
    chk("wrdiv_stored", o_empty, 0);
    start_div(t);
    push_exp(10'd256, t + PER);
    drain(30);

    // div on empty FIFO is a no-op
    chk("empty_before", o_empty, 1);
    div = 1'b1;
    tick();
    div = 1'b0;
    chk("empty_div_ready", o_ready, 1);
    repeat (15) tick();
    chk("empty_div_ready_late", o_ready, 1);

    // reset during DIV of second element
    wr_elem(4'h1); wr_elem(4'h1); wr_elem(4'h2);
    start_div(t);
    push_exp(10'd64, t + PER);
    while (cyc < t + PER + 3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_empty", o_empty, 1);
    chk("midrst_out",   out,     0);
    chk("midrst_valid", o_valid, 0);
    repeat (30) tick();
    chk("midrst_quiet", o_valid, 0);
    wr_elem(4'h2); wr_elem(4'h2);
    start_div(t);
    push_exp(10'd128, t + PER); push_exp(10'd128, t + 2*PER);
    drain(40);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/norm_seq.md
# norm_seq

Parametrised sequential normaliser for the attention datapath: accepts a vector of signed elements one per cycle, accumulates the sum of magnitudes, then emits each element's magnitude divided by that sum as an unsigned fixed-point fraction with `frac` fractional bits. It replaces the single-cycle combinational-divide normaliser. Width, vector depth and fraction precision are generalised, and the divide is an iterative restoring divider. It sits after the score/exp stage and feeds the weighted-value accumulator.

## Interface
- `bw`, 4: input element width, two's complement.
- `depth`, 16: maximum vector length, which is also the internal FIFO depth; must be a power of 2.
- `frac`, 8: fractional bits of the result.
- Derived: `sw = bw + $clog2(depth)` is the sum width; `ow = frac + 2` is the output width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears FSM, FIFO, sum and outputs.
- `in` input `bw`: signed element.
- `wr` input 1: write strobe for `in`.
- `div` input 1: start normalisation of the stored vector (level-sampled in IDLE).
- `out` output `ow`: result; reset value 0; holds its value between `o_valid` pulses.
- `o_valid` output 1: one-cycle pulse marking a new `out`; reset value 0.
- `o_ready` output 1: high in IDLE, meaning `wr`/`div` are accepted; reset value 1.
- `o_full` output 1: FIFO holds `depth` entries; reset value 0.
- `o_empty` output 1: FIFO holds 0 entries; reset value 1.

## Operation
- Magnitude: `mag = in[bw-1] ? -in : in`, `bw` bits unsigned. -2^(bw-1) maps to 2^(bw-1) with no saturation. Stored together with the sign bit (`bw+1` bits per FIFO entry).
- IDLE:
  - A write is accepted when `wr & !o_full`: it pushes {sign, mag} and sets `sum <= sum + mag`, `sw` bits, no overflow by construction.
  - `wr` while full is dropped; FIFO and sum are unchanged.
  - `div & !o_empty & !wr` goes to LOAD.
  - `div` with an empty FIFO is a no-op.
  - When `wr` and `div` are asserted in the same cycle, `wr` wins and `div` is ignored.
- LOAD: pop one entry; numerator = mag << frac; clear quotient; iteration counter = frac+1; go to DIV.
- DIV: restoring division by `sum`, one quotient bit per cycle (MSB first), for frac+1 cycles, then OUT.
  - Quotient is at most 2^frac because mag ≤ sum, so frac+1 bits suffice.
  - If `sum == 0`, the quotient is forced to 0. No X and no divide-by-zero behaviour.
- OUT:
  - `out <= {1'b0, q}` and `o_valid <= 1` for one cycle.
  - If the FIFO is still non-empty, go to LOAD. Otherwise clear `sum` and go to IDLE.
- Outside IDLE, `wr` and `div` are ignored (`o_ready` = 0).
- `reset` in any state: next cycle is IDLE, FIFO empty, sum 0, `out` 0, `o_valid` 0. Any in-flight result is discarded.

## Timing
- A write in cycle t is visible in `sum` and the FIFO count at t+1; `o_full`/`o_empty` update at t+1.
- `div` is sampled at edge t:
  - LOAD in cycle t+1.
  - DIV in cycles t+2..t+frac+2.
  - OUT in cycle t+frac+3, with `o_valid` high and `out` valid during the cycle after that edge.
- Element period is frac+3 cycles. An N-element vector completes in N·(frac+3) cycles after `div`.
- `o_ready` rises in the cycle after the last OUT. A new `wr` is accepted from that cycle on.

## Configuration
- `NORM_SIGNED_OUT_EN`:
  - Defined: OUT writes the two's-complement negation of `{1'b0, q}` when the stored sign is 1, so `out` is a signed `ow`-bit value.
  - Undefined: the sign is not stored (FIFO entries are `bw` bits), and `out` is always the non-negative magnitude ratio with its MSB equal to 0.

## Test plan
- bw=4, frac=8, depth=8: write 1, -2, 1, then `div`.
  - `out` = 64, 128, 64; `o_valid` pulses 11 cycles apart.
  - The first pulse is 11 cycles after `div`.
  - Then `o_ready`=1 and sum=0.
  - With `NORM_SIGNED_OUT_EN`, the second result is -128 (10'h380).
- Single element -8, then `div`: `out` = 256 (max quotient, no overflow). With the macro, the result is -256.
- Write 0, 0, 0, then `div`: three results of 0 (sum==0 path); no X on `out`.
- Eight writes of 3, then a ninth `wr` of 7:
  - `o_full`=1 and the ninth write is dropped.
  - `div` then yields eight results of 32.
- `wr`=1 and `div`=1 in the same IDLE cycle: the element is stored and no normalisation starts. `div` with an empty FIFO: `o_ready` stays 1 and there is no `o_valid`.
- Assert `reset` mid-DIV on the second of three elements: next cycle IDLE, `o_empty`=1, `out`=0, and no further `o_valid`. A fresh vector 2, 2 then gives 128, 128.
